// File: rtl/calc_pkg.sv
// calc_pkg: display FSM states, active-high {g..a} segment constants and BCD digit LUT (codes >9 blank)
package calc_pkg;
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} disp_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [15:0][6:0] SEG_LUT = {{6{SEG_BLANK}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                          7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
endpackage

// File: rtl/bcd_to_seven_seg.sv
// bcd_to_seven_seg: bcd[4] + blank -> seg[7] active-high {g..a}; blank forces all segments off
module bcd_to_seven_seg
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_LUT[bcd];
endmodule

// File: rtl/signed_result_display.sv
// signed_result_display: handshake-captured signed byte -> sign+BCD via double-dabble -> scanned 4-digit 7-seg (clk, rst, result_in/valid/ready, done, seg, an)
module signed_result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic       result_ready,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);
  disp_state_t state;
  logic sign, d_sign;
  logic [7:0] mag;
  logic [11:0] bcd, adj, d_bcd;
  logic [2:0] cnt;
  logic [RW-1:0] rc;
  logic [1:0] idx;
  logic [3:0] dig, an_hi;
  logic blk;
  logic [6:0] dec, pat;
  assign result_ready = state == IDLE;
  for (genvar g = 0; g < 3; g++) begin : g_adj
    assign adj[g*4 +: 4] = bcd[g*4 +: 4] >= 4'd5 ? bcd[g*4 +: 4] + 4'd3 : bcd[g*4 +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      sign <= 1'b0;
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      d_sign <= 1'b0;
      d_bcd <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (result_valid) begin
          state <= CONV;
          sign <= result_in[7];
          mag <= result_in[7] ? -result_in : result_in;
          bcd <= '0;
          cnt <= '0;
        end
        CONV: begin
          {bcd, mag} <= {adj[10:0], mag, 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= UPDATE;
        end
        default: begin
          state <= IDLE;
          done <= 1'b1;
          d_sign <= sign;
          d_bcd <= bcd;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= '0;
      idx <= '0;
    end else begin
      rc <= rc == RC_MAX ? '0 : rc + RW'(1);
      if (rc == RC_MAX) idx <= idx + 2'd1;
    end
  end
  // leading-zero suppression: hundreds blank if 0, tens blank only when hundreds also 0
  assign dig = idx == 2'd2 ? d_bcd[11:8] : idx == 2'd1 ? d_bcd[7:4] : d_bcd[3:0];
  assign blk = idx == 2'd2 ? d_bcd[11:8] == 4'd0 : idx == 2'd1 ? d_bcd[11:4] == 8'd0 : 1'b0;
  bcd_to_seven_seg u_dec (.bcd(dig), .blank(blk), .seg(dec));
  assign pat = idx == 2'd3 ? (d_sign ? SEG_MINUS : SEG_BLANK) : dec;
  assign an_hi = 4'b0001 << idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= ACTIVE_LOW ? ~SEG_LUT[0] : SEG_LUT[0];
      an <= ACTIVE_LOW ? 4'b1110 : 4'b0001;
    end else begin
      seg <= ACTIVE_LOW ? ~pat : pat;
      an <= ACTIVE_LOW ? ~an_hi : an_hi;
    end
  end
endmodule

// File: tb/tb_signed_result_display.sv
// tb_signed_result_display: randomized + directed bench with a value-level display model for signed_result_display
module tb_signed_result_display;
  logic clk = 1'b0, rst = 1'b1, result_valid = 1'b0;
  logic [7:0] result_in = '0;
  logic result_ready, done;
  logic [6:0] seg;
  logic [3:0] an;
  int vectors = 0, miscompares = 0;
  signed_result_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .result_valid(result_valid),
    .result_ready(result_ready), .done(done), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction
  function automatic logic [6:0] digit_seg(int v, int pos);
    int a, h, t, o;
    logic [6:0] p;
    a = v < 0 ? -v : v;
    h = a / 100;
    t = (a / 10) % 10;
    o = a % 10;
    case (pos)
      3: p = v < 0 ? 7'h40 : 7'h00;
      2: p = h != 0 ? glyph(h) : 7'h00;
      1: p = (h != 0 || t != 0) ? glyph(t) : 7'h00;
      default: p = glyph(o);
    endcase
    return ~p;
  endfunction
  int disp = 0, pend = 0, wait_cnt = 0, edges = 0;
  bit busy = 0, was_busy = 0, armed = 0, exp_done = 0;
  logic [6:0] exp_seg = '1;
  logic [3:0] exp_an = '1;
  always @(posedge clk) begin
    if (rst) begin
      disp = 0; busy = 0; edges = 0; exp_done = 0; armed = 1;
      exp_seg = digit_seg(0, 0);
      exp_an = 4'b1110;
    end else begin
      exp_seg = digit_seg(disp, (edges / 4) % 4);
      exp_an = ~(4'b0001 << ((edges / 4) % 4));
      edges++;
      exp_done = 0;
      was_busy = busy;
      if (busy) begin
        wait_cnt++;
        if (wait_cnt == 9) begin disp = pend; busy = 0; exp_done = 1; end
      end
      if (!was_busy && result_valid) begin
        pend = int'($signed(result_in)); busy = 1; wait_cnt = 0;
      end
    end
  end
  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("ready", 8'(result_ready), 8'(!busy));
    chk("done", 8'(done), 8'(exp_done));
    chk("seg", 8'(seg), 8'(exp_seg));
    chk("an", 8'(an), 8'(exp_an));
  end
  task automatic check_digit(int d, logic [6:0] lit);
    int n = 0;
    logic [3:0] e;
    e = ~(4'b0001 << d);
    while (an !== e && n < 40) begin @(negedge clk); n++; end
    chk($sformatf("lit_an%0d", d), 8'(an), 8'(e));
    chk($sformatf("lit_seg%0d", d), 8'(seg), 8'(lit));
  endtask
  task automatic check_all(logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0);
    check_digit(3, s3); check_digit(2, s2); check_digit(1, s1); check_digit(0, s0);
  endtask
  task automatic send(logic [7:0] v, bit junk, output int lat);
    int n = 0;
    while (!result_ready && n < 40) begin @(negedge clk); n++; end
    result_in = v;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      result_valid = junk & 1'($urandom);
      result_in = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    result_valid = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, dcount, p;
    logic [3:0] prev;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 8'(result_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    check_all(7'h7F, 7'h7F, 7'h7F, 7'h40);
    send(8'h7F, 1'b0, lat);
    chk("lat_127", 8'(lat), 8'd9);
    check_all(7'h7F, 7'h79, 7'h24, 7'h78);
    send(8'h80, 1'b0, lat);
    chk("lat_m128", 8'(lat), 8'd9);
    check_all(7'h3F, 7'h79, 7'h24, 7'h00);
    send(8'hFB, 1'b0, lat);
    check_all(7'h3F, 7'h7F, 7'h7F, 7'h12);
    result_in = 8'hE2; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    result_in = 8'h01; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("lat_m30", 8'(lat + 3), 8'd9);
    repeat (3) @(negedge clk);
    check_all(7'h3F, 7'h7F, 7'h30, 7'h40);
    result_in = 8'h15; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (15) begin @(negedge clk); dcount += done ? 1 : 0; end
    chk("abort_no_done", 8'(dcount), 8'd0);
    chk("abort_ready", 8'(result_ready), 8'd1);
    check_all(7'h7F, 7'h7F, 7'h7F, 7'h40);
    prev = an;
    lat = 0;
    while (an === prev && lat < 10) begin @(negedge clk); lat++; end
    p = 0;
    for (int k = 0; k < 4; k++) if (an === ~(4'b0001 << k)) p = k;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e;
      e = ~(4'b0001 << ((p + i / 4) % 4));
      chk("scan_seq", 8'(an), 8'(e));
      @(negedge clk);
    end
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 1) * $urandom_range(0, 6)) @(negedge clk);
      send(8'($urandom), 1'($urandom), lat);
      chk("lat_rand", 8'(lat), 8'd9);
    end
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
